alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the datapath word width.
REQ-002 The block SHALL have parameter REG_COUNT, default 16, the number of general registers (power of two); RW = log2(REG_COUNT).
REQ-003 The block SHALL have parameter OPW, default 5, the opcode field width.
REQ-004 The block SHALL have parameters MUL_OP, default 15, and DIV_OP, default 16, the two-result opcodes; LAST_OP, default 12, the highest three-register opcode.
REQ-005 The block SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of T1 wait cycles.
REQ-006 clock  in  1  single clock; all state changes on the rising edge.
REQ-007 clear  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  request one instruction cycle.
REQ-009 mem_ready  in  1  memory read data valid.
REQ-010 ir  in  DATA_WIDTH  instruction register value: opcode [DATA_WIDTH-1 -: OPW], Ra, Rb and Rc in the next three RW-bit fields.
REQ-011 pc_out, inc_pc, mar_in, z_in, zlo_out, zhi_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in  out  1 each  datapath strobes.
REQ-012 reg_out, reg_in  out  REG_COUNT  one-hot register bus-drive and load selects.
REQ-013 opcode_out  out  OPW  ALU operation.
REQ-014 busy, done, illegal, timeout  out  1  status.

Function
REQ-015 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and FAULT.
REQ-016 Outputs SHALL be decoded from the present state and ir only; they change only after a clock edge or clear.
REQ-017 All outputs SHALL be 0 in IDLE.
REQ-018 IDLE SHALL go to T0 when start=1.
REQ-019 T0 SHALL assert pc_out, inc_pc, mar_in and z_in, then go to T1.
REQ-020 T1 SHALL assert zlo_out, pc_in, read and mdr_in.
REQ-021 T1 SHALL go to T2 in the cycle mem_ready=1; otherwise it holds and increments a wait counter.
REQ-022 When the wait counter reaches MEM_TIMEOUT, T1 SHALL go to FAULT with timeout=1.
REQ-023 T2 SHALL assert mdr_out and ir_in.
REQ-024 From T2, an opcode in 0..LAST_OP, MUL_OP or DIV_OP SHALL go to T3; any other opcode SHALL go to FAULT with illegal=1.
REQ-025 T3 SHALL assert reg_out = one-hot(Rb) and y_in.
REQ-026 T4 SHALL assert reg_out = one-hot(Rc), opcode_out = ir opcode and z_in; opcode_out SHALL be 0 outside T4.
REQ-027 For three-register ops, T5 SHALL assert zlo_out and reg_in = one-hot(Ra), and assert done.
REQ-028 For MUL_OP/DIV_OP, T5 SHALL assert zlo_out and lo_in, and T6 SHALL assert zhi_out, hi_in and done.
REQ-029 Ra=R0 SHALL be written normally; there is no special case for R0.
REQ-030 After the final step, the next state SHALL be T0 if start=1 in that cycle (back-to-back), else IDLE.
REQ-031 start SHALL be ignored in all states other than IDLE and the final step.
REQ-032 FAULT SHALL last exactly one cycle with done=1 and no datapath strobes, then go to IDLE; illegal/timeout SHALL be valid only in FAULT.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 The wait counter SHALL clear on entry to T0.

Reset
REQ-035 clear=0 SHALL, asynchronously, force IDLE, zero the wait counter, and drive all outputs to 0, including mid-instruction.
REQ-036 After clear returns to 1, the first T0 SHALL occur no earlier than the first edge at which start=1.

Verification
REQ-037 clear pulsed low during T4 -> all strobes, reg_out, opcode_out and busy are 0 immediately; IDLE until start.
REQ-038 ir=0x28918000 (op 5, Ra=1, Rb=2, Rc=3), mem_ready=1 -> 6 busy cycles; T3 reg_out=0x0004 with y_in; T4 reg_out=0x0008 with opcode_out=5; T5 reg_in=0x0002 with zlo_out and done.
REQ-039 Same instruction with mem_ready asserted on the 4th T1 cycle -> T1 lasts 4 cycles with read held; 9 busy cycles total.
REQ-040 ir=0x78228000 (MUL, Rb=4, Rc=5) -> T5 has zlo_out and lo_in; T6 has zhi_out, hi_in and done; reg_in=0 throughout.
REQ-041 ir=0xF8000000 -> T0, T1, T2, then FAULT with illegal=1 and done=1 for one cycle, then IDLE. mem_ready held 0 -> FAULT with timeout=1 after 15 T1 cycles.
REQ-042 start held 1 across two instructions -> second T0 immediately follows first T5; busy never drops.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: fetch (T0-T2), operand/ALU steps (T3-T6)
// and a one-cycle FAULT step for illegal opcodes or memory-read timeouts.
module alu_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_COUNT   = 16,
    parameter int OPW         = 5,
    parameter int MUL_OP      = 15,
    parameter int DIV_OP      = 16,
    parameter int LAST_OP     = 12,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] ir,
    output logic                  pc_out,
    output logic                  inc_pc,
    output logic                  mar_in,
    output logic                  z_in,
    output logic                  zlo_out,
    output logic                  zhi_out,
    output logic                  pc_in,
    output logic                  read,
    output logic                  mdr_in,
    output logic                  mdr_out,
    output logic                  ir_in,
    output logic                  y_in,
    output logic                  hi_in,
    output logic                  lo_in,
    output logic [REG_COUNT-1:0]  reg_out,
    output logic [REG_COUNT-1:0]  reg_in,
    output logic [OPW-1:0]        opcode_out,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic                  timeout
);

    localparam int RW = $clog2(REG_COUNT);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_q, wait_d;
    logic [CW-1:0]  wait_inc;
    logic [OPW-1:0] op;
    logic [RW-1:0]  ra, rb, rc;
    logic           two_result;
    logic           legal_op;

    assign op = ir[DATA_WIDTH-1 -: OPW];
    assign ra = ir[DATA_WIDTH-OPW-1 -: RW];
    assign rb = ir[DATA_WIDTH-OPW-RW-1 -: RW];
    assign rc = ir[DATA_WIDTH-OPW-2*RW-1 -: RW];

    generate
        if (DATA_WIDTH > OPW + 3*RW) begin : g_unused
            logic unused_ir_bits;
            assign unused_ir_bits = ^ir[DATA_WIDTH-OPW-3*RW-1:0];
        end
    endgenerate

    assign two_result = (op == OPW'(MUL_OP)) || (op == OPW'(DIV_OP));
    assign legal_op   = (op <= OPW'(LAST_OP)) || two_result;
    assign wait_inc   = wait_q + CW'(1);

    function automatic logic [REG_COUNT-1:0] onehot(input logic [RW-1:0] idx);
        logic [REG_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:  if (start) state_d = T0;
            T0:    state_d = T1;
            T1: begin
                if (mem_ready) begin
                    state_d = T2;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == CW'(MEM_TIMEOUT)) state_d = FAULT;
                end
            end
            T2:    state_d = legal_op ? T3 : FAULT;
            T3:    state_d = T4;
            T4:    state_d = T5;
            T5:    state_d = two_result ? T6 : (start ? T0 : IDLE);
            T6:    state_d = start ? T0 : IDLE;
            FAULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == T0) wait_d = '0;
    end

    // Outputs are registered from the state being entered so they only move on an edge or clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            pc_out     <= 1'b0;
            inc_pc     <= 1'b0;
            mar_in     <= 1'b0;
            z_in       <= 1'b0;
            zlo_out    <= 1'b0;
            zhi_out    <= 1'b0;
            pc_in      <= 1'b0;
            read       <= 1'b0;
            mdr_in     <= 1'b0;
            mdr_out    <= 1'b0;
            ir_in      <= 1'b0;
            y_in       <= 1'b0;
            hi_in      <= 1'b0;
            lo_in      <= 1'b0;
            reg_out    <= '0;
            reg_in     <= '0;
            opcode_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            pc_out     <= 1'b0;
            inc_pc     <= 1'b0;
            mar_in     <= 1'b0;
            z_in       <= 1'b0;
            zlo_out    <= 1'b0;
            zhi_out    <= 1'b0;
            pc_in      <= 1'b0;
            read       <= 1'b0;
            mdr_in     <= 1'b0;
            mdr_out    <= 1'b0;
            ir_in      <= 1'b0;
            y_in       <= 1'b0;
            hi_in      <= 1'b0;
            lo_in      <= 1'b0;
            reg_out    <= '0;
            reg_in     <= '0;
            opcode_out <= '0;
            busy       <= (state_d != IDLE);
            done       <= 1'b0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
            case (state_d)
                T0: begin
                    pc_out <= 1'b1;
                    inc_pc <= 1'b1;
                    mar_in <= 1'b1;
                    z_in   <= 1'b1;
                end
                T1: begin
                    zlo_out <= 1'b1;
                    pc_in   <= 1'b1;
                    read    <= 1'b1;
                    mdr_in  <= 1'b1;
                end
                T2: begin
                    mdr_out <= 1'b1;
                    ir_in   <= 1'b1;
                end
                T3: begin
                    reg_out <= onehot(rb);
                    y_in    <= 1'b1;
                end
                T4: begin
                    reg_out    <= onehot(rc);
                    opcode_out <= op;
                    z_in       <= 1'b1;
                end
                T5: begin
                    zlo_out <= 1'b1;
                    if (two_result) begin
                        lo_in <= 1'b1;
                    end else begin
                        reg_in <= onehot(ra);
                        done   <= 1'b1;
                    end
                end
                T6: begin
                    zhi_out <= 1'b1;
                    hi_in   <= 1'b1;
                    done    <= 1'b1;
                end
                FAULT: begin
                    done    <= 1'b1;
                    illegal <= (state_q == T2);
                    timeout <= (state_q == T1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer with a step-list reference model.
module tb_alu_sequencer;

    localparam int S_IDLE = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_T3 = 4, S_T4 = 5,
                   S_T5 = 6, S_T6 = 7, S_FI = 8, S_FT = 9;

    logic        clk = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir;
    logic pc_out, inc_pc, mar_in, z_in, zlo_out, zhi_out, pc_in, read;
    logic mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in;
    logic [15:0] reg_out, reg_in;
    logic [4:0]  opcode_out;
    logic busy, done, illegal, timeout;
    logic [63:0] obs;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  in_idle  = 1'b1;

    alu_sequencer dut (
        .clock(clk), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .pc_in(pc_in), .read(read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .reg_out(reg_out), .reg_in(reg_in),
        .opcode_out(opcode_out), .busy(busy), .done(done), .illegal(illegal),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign obs = {9'b0, busy, done, illegal, timeout, pc_out, inc_pc, mar_in, z_in,
                  zlo_out, zhi_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                  hi_in, lo_in, reg_out, reg_in, opcode_out};

    // Expected output vector for one step of an instruction, from the field arithmetic.
    function automatic logic [63:0] expv(int step, logic [31:0] instr);
        int opc, ra, rb, rc;
        logic b, d, il, to, pco, inc, mar, z, zlo, zhi, pci, rd, mdri, mdro, iri, yi, hii, loi;
        logic [15:0] ro, ri;
        logic [4:0]  oc;
        opc = int'(instr >> 27);
        ra  = int'((instr >> 23) & 32'hF);
        rb  = int'((instr >> 19) & 32'hF);
        rc  = int'((instr >> 15) & 32'hF);
        {b, d, il, to, pco, inc, mar, z, zlo, zhi, pci, rd, mdri, mdro, iri, yi, hii, loi} = '0;
        ro = '0; ri = '0; oc = '0;
        b = (step != S_IDLE);
        case (step)
            S_T0: {pco, inc, mar, z} = 4'hF;
            S_T1: {zlo, pci, rd, mdri} = 4'hF;
            S_T2: {mdro, iri} = 2'b11;
            S_T3: begin ro = 16'(1) << rb; yi = 1'b1; end
            S_T4: begin ro = 16'(1) << rc; oc = 5'(opc); z = 1'b1; end
            S_T5: begin
                zlo = 1'b1;
                if (opc == 15 || opc == 16) loi = 1'b1;
                else begin ri = 16'(1) << ra; d = 1'b1; end
            end
            S_T6: {zhi, hii, d} = 3'b111;
            S_FI: {d, il} = 2'b11;
            S_FT: {d, to} = 2'b11;
            default: ;
        endcase
        return {9'b0, b, d, il, to, pco, inc, mar, z, zlo, zhi, pci, rd, mdri, mdro,
                iri, yi, hii, loi, ro, ri, oc};
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // d = T1 cycle on which mem_ready rises (1..15); anything else never rises.
    task automatic run_instr(input string tag, input logic [31:0] instr, input int d, input bit b2b);
        int  steps[$];
        bit  rdy[$];
        int  opc;
        bit  legal, to_flag, fault, chain;
        int  n1;
        opc     = int'(instr >> 27);
        legal   = (opc <= 12) || opc == 15 || opc == 16;
        to_flag = !(d >= 1 && d <= 15);
        n1      = to_flag ? 15 : d;
        fault   = to_flag || !legal;
        chain   = b2b && !fault;
        steps.push_back(S_T0); rdy.push_back(1'($urandom_range(0, 1)));
        for (int k = 1; k <= n1; k++) begin
            steps.push_back(S_T1);
            rdy.push_back(!to_flag && k == n1);
        end
        if (to_flag) begin
            steps.push_back(S_FT);
        end else begin
            steps.push_back(S_T2);
            if (!legal) steps.push_back(S_FI);
            else begin
                steps.push_back(S_T3);
                steps.push_back(S_T4);
                steps.push_back(S_T5);
                if (opc == 15 || opc == 16) steps.push_back(S_T6);
            end
        end
        while (rdy.size() < steps.size()) rdy.push_back(1'($urandom_range(0, 1)));
        if (in_idle) start = 1'b1;
        for (int i = 0; i < steps.size(); i++) begin
            @(posedge clk); #1;
            check($sformatf("%s ir=%h step%0d", tag, instr, i), obs, expv(steps[i], instr));
            if (i == 0) ir = instr;
            mem_ready = rdy[i];
            start = (i == steps.size() - 1) ? chain : 1'($urandom_range(0, 1));
        end
        if (!chain) begin
            @(posedge clk); #1;
            check($sformatf("%s idle_after", tag), obs, expv(S_IDLE, instr));
        end
        in_idle = !chain;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [31:0] instr;
        int opc, d, r;
        bit b2b;

        clear = 1'b0; start = 1'b1; mem_ready = 1'b1; ir = 32'h2891_8000;
        repeat (2) @(posedge clk);
        #1 check("reset_hold", obs, expv(S_IDLE, ir));
        @(negedge clk); clear = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_no_start%0d", i), obs, expv(S_IDLE, ir));
        end

        run_instr("add_fast", 32'h2891_8000, 1, 1'b0);
        run_instr("add_wait4", 32'h2891_8000, 4, 1'b0);
        run_instr("mul", 32'h7822_8000, 1, 1'b0);
        run_instr("div_r0", 32'h8000_0000, 2, 1'b0);
        run_instr("illegal", 32'hF800_0000, 1, 1'b0);
        run_instr("tmo", 32'h2891_8000, 0, 1'b0);
        run_instr("ready_last", 32'h6000_0000, 15, 1'b0);
        run_instr("b2b_a", 32'h2891_8000, 1, 1'b1);
        run_instr("b2b_b", 32'h2891_8000, 1, 1'b0);

        // Asynchronous clear while T4 is active.
        ir = 32'h2891_8000; start = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("pre_clear_t4", obs, expv(S_T4, ir));
        clear = 1'b0;
        #1 check("clear_in_t4", obs, expv(S_IDLE, ir));
        @(negedge clk); clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_after_clear%0d", i), obs, expv(S_IDLE, ir));
        end
        in_idle = 1'b1;

        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) opc = int'($urandom_range(0, 12));
            else if (r < 8) opc = ($urandom_range(0, 1) == 1) ? 15 : 16;
            else begin
                do opc = int'($urandom_range(13, 31)); while (opc == 15 || opc == 16);
            end
            r = int'($urandom_range(0, 9));
            if (r < 8) d = int'($urandom_range(1, 6));
            else if (r == 8) d = 15;
            else d = 0;
            b2b = 1'($urandom_range(0, 1));
            rnd = $urandom();
            instr = {opc[4:0], rnd[26:0]};
            run_instr($sformatf("rnd%0d", n), instr, d, b2b);
        end
        if (!in_idle) begin
            start = 1'b0;
            run_instr("drain", 32'h0000_0000, 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
